// File: rtl/bank_out_arb_buf.sv
// bank_out_arb_buf
// ----------------
// Merges the read-only bank response (r_*) and the read-write bank response
// (rw_*) of every lane onto one registered port response. When both banks
// answer on the same lane in the same cycle, or when older responses are
// still waiting, the responses that cannot go out now are parked in a small
// per-lane circular buffer. They are replayed later in arrival order, with r
// ahead of rw within a single cycle.
//
// Ports (lane i of every bus sits at [i*W +: W]):
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   rw_valid         rw-bank response valid, one bit per lane
//   rw_data          rw-bank response data, DATA_W per lane
//   rw_req_tag       rw-bank request tag, TAG_W per lane
//   r_valid          r-bank response valid, one bit per lane
//   r_data           r-bank response data, DATA_W per lane
//   r_req_tag        r-bank request tag, TAG_W per lane
//   port_valid       registered port response valid (one-cycle pulse)
//   port_data        registered port response data, zero when idle
//   port_req_tag     registered port response tag, zero when idle
//   port_almost_full lane buffer holds DEPTH-1 or more entries
//   overflow         sticky: the lane has dropped a response since reset

module bank_out_arb_buf #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          rw_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   rw_data,
  input  logic [NUM_PORTS*TAG_W-1:0]    rw_req_tag,
  input  logic [NUM_PORTS-1:0]          r_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   r_data,
  input  logic [NUM_PORTS*TAG_W-1:0]    r_req_tag,
  output logic [NUM_PORTS-1:0]          port_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   port_data,
  output logic [NUM_PORTS*TAG_W-1:0]    port_req_tag,
  output logic [NUM_PORTS-1:0]          port_almost_full,
  output logic [NUM_PORTS-1:0]          overflow
);

  // An entry packs data above tag so a single vector moves through the
  // buffer and the output register.
  localparam int ENTRY_W = DATA_W + TAG_W;
  // DEPTH is a power of two, so pointers wrap simply by overflowing.
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The count has to represent DEPTH itself (buffer completely full).
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef logic [ENTRY_W-1:0] entry_t;

  // Per-lane buffer storage and bookkeeping.
  entry_t           mem      [NUM_PORTS][DEPTH];
  logic [PTR_W-1:0] rd_ptr   [NUM_PORTS];
  logic [PTR_W-1:0] wr_ptr   [NUM_PORTS];
  logic [CNT_W-1:0] count    [NUM_PORTS];

  // Registered port response and sticky drop flag.
  logic [NUM_PORTS-1:0] valid_q;
  logic [NUM_PORTS-1:0] ovf_q;
  entry_t               out_q    [NUM_PORTS];

  // Per-lane decisions for the current cycle.
  entry_t           r_ent      [NUM_PORTS];
  entry_t           rw_ent     [NUM_PORTS];
  entry_t           head_ent   [NUM_PORTS];
  entry_t           sel_ent    [NUM_PORTS];
  entry_t           cand0_ent  [NUM_PORTS];
  entry_t           cand1_ent  [NUM_PORTS];
  logic [PTR_W-1:0] wr_ptr_p1  [NUM_PORTS];
  logic [CNT_W-1:0] free_slots [NUM_PORTS];
  logic [CNT_W-1:0] count_next [NUM_PORTS];
  logic [NUM_PORTS-1:0] pop;
  logic [NUM_PORTS-1:0] sel_valid;
  logic [NUM_PORTS-1:0] cand0_v;
  logic [NUM_PORTS-1:0] cand1_v;
  logic [NUM_PORTS-1:0] acc0;
  logic [NUM_PORTS-1:0] acc1;
  logic [NUM_PORTS-1:0] drop;

  // Selection and push planning for every lane.
  // A non-empty buffer always wins the port: its head is the oldest response,
  // so sending it first keeps arrival order, and every new response (r first,
  // then rw) queues behind it. With an empty buffer the new r response goes
  // straight out and a colliding rw response is parked; a lone rw goes out.
  // The push candidates are compacted into cand0/cand1 in arrival order, so
  // capacity limits always discard the later arrival (rw before r).
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      r_ent[i]     = {r_data[i*DATA_W +: DATA_W], r_req_tag[i*TAG_W +: TAG_W]};
      rw_ent[i]    = {rw_data[i*DATA_W +: DATA_W], rw_req_tag[i*TAG_W +: TAG_W]};
      head_ent[i]  = mem[i][rd_ptr[i]];
      wr_ptr_p1[i] = wr_ptr[i] + PTR_W'(1);

      pop[i]       = (count[i] != '0);
      sel_valid[i] = 1'b0;
      sel_ent[i]   = '0;
      cand0_v[i]   = 1'b0;
      cand0_ent[i] = '0;
      cand1_v[i]   = 1'b0;
      cand1_ent[i] = '0;

      if (pop[i]) begin
        sel_valid[i] = 1'b1;
        sel_ent[i]   = head_ent[i];
        if (r_valid[i]) begin
          cand0_v[i]   = 1'b1;
          cand0_ent[i] = r_ent[i];
          cand1_v[i]   = rw_valid[i];
          cand1_ent[i] = rw_ent[i];
        end else begin
          cand0_v[i]   = rw_valid[i];
          cand0_ent[i] = rw_ent[i];
        end
      end else if (r_valid[i]) begin
        sel_valid[i] = 1'b1;
        sel_ent[i]   = r_ent[i];
        cand0_v[i]   = rw_valid[i];
        cand0_ent[i] = rw_ent[i];
      end else if (rw_valid[i]) begin
        sel_valid[i] = 1'b1;
        sel_ent[i]   = rw_ent[i];
      end

      // The slot freed by this cycle's pop is reusable in the same cycle.
      free_slots[i] = CNT_W'(DEPTH) - count[i] + CNT_W'(pop[i]);
      acc0[i]       = cand0_v[i] && (free_slots[i] >= CNT_W'(1));
      acc1[i]       = cand1_v[i] && (free_slots[i] >= CNT_W'(2));
      drop[i]       = (cand0_v[i] && !acc0[i]) || (cand1_v[i] && !acc1[i]);
      count_next[i] = count[i] - CNT_W'(pop[i]) + CNT_W'(acc0[i]) + CNT_W'(acc1[i]);
    end
  end

  // Buffer storage. The contents need no reset: an entry is only ever read
  // while the count says it holds valid data. cand1 is only accepted together
  // with cand0, so it always lands in the slot after cand0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (acc0[i]) begin
          mem[i][wr_ptr[i]] <= cand0_ent[i];
        end
        if (acc1[i]) begin
          mem[i][wr_ptr_p1[i]] <= cand1_ent[i];
        end
      end
    end
  end

  // Pointers, occupancy, output register and the sticky drop flag.
  // Reset throws away whatever is buffered by zeroing the pointers and count;
  // inputs present during reset are never selected or pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        valid_q[i] <= sel_valid[i];
        out_q[i]   <= sel_ent[i];
        count[i]   <= count_next[i];
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        wr_ptr[i] <= wr_ptr[i] + PTR_W'(acc0[i]) + PTR_W'(acc1[i]);
        if (drop[i]) begin
          ovf_q[i] <= 1'b1;
        end
      end
    end
  end

  // Unpack the registered entries onto the flat port buses. The almost-full
  // flag comes straight from the registered count so upstream sees it early.
  always_comb begin
    port_data        = '0;
    port_req_tag     = '0;
    port_almost_full = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_data[i*DATA_W +: DATA_W]  = out_q[i][ENTRY_W-1:TAG_W];
      port_req_tag[i*TAG_W +: TAG_W] = out_q[i][TAG_W-1:0];
      port_almost_full[i]            = (count[i] >= CNT_W'(DEPTH - 1));
    end
  end

  assign port_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_bank_out_arb_buf.sv
// tb_bank_out_arb_buf
// -------------------
// Self-checking bench for bank_out_arb_buf. A queue-based model of each lane
// predicts the port outputs every cycle; directed sequences additionally pin
// hand-computed values, then a randomized phase with occasional resets runs.

module tb_bank_out_arb_buf;

  localparam int NP    = 3;
  localparam int DW    = 16;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    rw_valid;
  logic [NP*DW-1:0] rw_data;
  logic [NP*TW-1:0] rw_req_tag;
  logic [NP-1:0]    r_valid;
  logic [NP*DW-1:0] r_data;
  logic [NP*TW-1:0] r_req_tag;
  logic [NP-1:0]    port_valid;
  logic [NP*DW-1:0] port_data;
  logic [NP*TW-1:0] port_req_tag;
  logic [NP-1:0]    port_almost_full;
  logic [NP-1:0]    overflow;

  // Staged inputs for the next cycle, built lane by lane.
  logic [NP-1:0]    s_rv, s_rwv;
  logic [NP*DW-1:0] s_rd, s_rwd;
  logic [NP*TW-1:0] s_rt, s_rwt;

  // Model state and its predictions for the current port outputs.
  ent_t          mq [NP][$];
  ent_t          arr[$];
  logic [NP-1:0] exp_v, exp_af, exp_ovf;
  logic [DW-1:0] exp_d [NP];
  logic [TW-1:0] exp_t [NP];

  int   tests_run = 0;
  int   failures  = 0;
  logic chk_en    = 1'b0;

  bank_out_arb_buf #(
    .NUM_PORTS(NP),
    .DATA_W   (DW),
    .TAG_W    (TW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rw_valid        (rw_valid),
    .rw_data         (rw_data),
    .rw_req_tag      (rw_req_tag),
    .r_valid         (r_valid),
    .r_data          (r_data),
    .r_req_tag       (r_req_tag),
    .port_valid      (port_valid),
    .port_data       (port_data),
    .port_req_tag    (port_req_tag),
    .port_almost_full(port_almost_full),
    .overflow        (overflow)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Lane model: every response arriving in a cycle joins an ordered arrival
  // list (r before rw). If older responses wait in the queue the oldest one
  // is sent; otherwise the first arrival is sent directly. Remaining arrivals
  // join the queue while it has room and are dropped (raising the sticky
  // overflow) once it holds DEPTH entries.
  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (rst) begin
        mq[i].delete();
        exp_v[i]   = 1'b0;
        exp_d[i]   = '0;
        exp_t[i]   = '0;
        exp_ovf[i] = 1'b0;
        exp_af[i]  = 1'b0;
      end else begin
        ent_t sent;
        arr.delete();
        if (r_valid[i])  arr.push_back('{d: r_data[i*DW +: DW],  t: r_req_tag[i*TW +: TW]});
        if (rw_valid[i]) arr.push_back('{d: rw_data[i*DW +: DW], t: rw_req_tag[i*TW +: TW]});
        exp_v[i] = 1'b0;
        sent     = '0;
        if (mq[i].size() > 0) begin
          sent     = mq[i].pop_front();
          exp_v[i] = 1'b1;
        end else if (arr.size() > 0) begin
          sent     = arr.pop_front();
          exp_v[i] = 1'b1;
        end
        exp_d[i] = sent.d;
        exp_t[i] = sent.t;
        foreach (arr[k]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(arr[k]);
          else                      exp_ovf[i] = 1'b1;
        end
        exp_af[i] = (mq[i].size() >= DEPTH - 1);
      end
    end
  end

  // Single comparison point: reports a mismatch and keeps the counters.
  task automatic checkOutput(input string name, input int lane,
                             input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s lane %0d: got %0h expected %0h (t=%0t)", name, lane, act, exp, $time);
    end
  endtask

  // Compare process: half a cycle after each edge, every lane's outputs
  // must match what the model predicts.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NP; i++) begin
        checkOutput("model_valid", i, 32'(port_valid[i]),           32'(exp_v[i]));
        checkOutput("model_data",  i, 32'(port_data[i*DW +: DW]),   32'(exp_d[i]));
        checkOutput("model_tag",   i, 32'(port_req_tag[i*TW +: TW]), 32'(exp_t[i]));
        checkOutput("model_afull", i, 32'(port_almost_full[i]),     32'(exp_af[i]));
        checkOutput("model_ovf",   i, 32'(overflow[i]),             32'(exp_ovf[i]));
      end
    end
  end

  // Hand-computed expectation for one lane's port response.
  task automatic checkLane(input string name, input int lane, input logic v,
                           input logic [DW-1:0] d, input logic [TW-1:0] t);
    checkOutput({name, "_valid"}, lane, 32'(port_valid[lane]),           32'(v));
    checkOutput({name, "_data"},  lane, 32'(port_data[lane*DW +: DW]),   32'(d));
    checkOutput({name, "_tag"},   lane, 32'(port_req_tag[lane*TW +: TW]), 32'(t));
  endtask

  task automatic stageR(input int lane, input logic [DW-1:0] d, input logic [TW-1:0] t);
    s_rv[lane]            = 1'b1;
    s_rd[lane*DW +: DW]   = d;
    s_rt[lane*TW +: TW]   = t;
  endtask

  task automatic stageRw(input int lane, input logic [DW-1:0] d, input logic [TW-1:0] t);
    s_rwv[lane]           = 1'b1;
    s_rwd[lane*DW +: DW]  = d;
    s_rwt[lane*TW +: TW]  = t;
  endtask

  // Drives the staged inputs for one clock edge, clears the staging area and
  // returns at the following falling edge, when that edge's results are
  // visible on the ports.
  task automatic applyStimulus(input logic rst_i);
    rst        = rst_i;
    r_valid    = s_rv;
    r_data     = s_rd;
    r_req_tag  = s_rt;
    rw_valid   = s_rwv;
    rw_data    = s_rwd;
    rw_req_tag = s_rwt;
    s_rv  = '0; s_rd  = '0; s_rt  = '0;
    s_rwv = '0; s_rwd = '0; s_rwt = '0;
    @(negedge clk);
  endtask

  // Directed sequences with literal expectations, then randomized traffic.
  initial begin
    logic [DW-1:0] drain_d [4];
    logic [TW-1:0] drain_t [4];

    s_rv  = '0; s_rd  = '0; s_rt  = '0;
    s_rwv = '0; s_rwd = '0; s_rwt = '0;
    rst = 1'b1;
    r_valid = '0; r_data = '0; r_req_tag = '0;
    rw_valid = '0; rw_data = '0; rw_req_tag = '0;
    @(negedge clk);
    applyStimulus(1'b1);
    chk_en = 1'b1;

    // Reset state.
    checkOutput("reset_valid", 0, 32'(port_valid),       32'd0);
    checkOutput("reset_data",  0, 32'(port_data[31:0]),  32'd0);
    checkOutput("reset_afull", 0, 32'(port_almost_full), 32'd0);
    checkOutput("reset_ovf",   0, 32'(overflow),         32'd0);

    // Single source on lane 0.
    stageR(0, 16'hA5A5, 2'd1);
    applyStimulus(1'b0);
    checkLane("single", 0, 1'b1, 16'hA5A5, 2'd1);
    applyStimulus(1'b0);
    checkLane("single_idle", 0, 1'b0, 16'h0000, 2'd0);

    // Collision on lane 1: r first, rw one cycle later.
    stageR(1, 16'h1111, 2'd0);
    stageRw(1, 16'h2222, 2'd3);
    applyStimulus(1'b0);
    checkLane("coll_r", 1, 1'b1, 16'h1111, 2'd0);
    applyStimulus(1'b0);
    checkLane("coll_rw", 1, 1'b1, 16'h2222, 2'd3);
    applyStimulus(1'b0);
    checkLane("coll_idle", 1, 1'b0, 16'h0000, 2'd0);
    checkOutput("coll_ovf", 1, 32'(overflow[1]), 32'd0);

    // Burst on lane 2: both sources for 4 cycles, then 2 more to overflow.
    // Outputs follow r0,rw0,r1,rw1,r2,rw2; rw4 and rw5 are dropped.
    for (int k = 0; k < 6; k++) begin
      stageR(2, 16'(16'h3000 + k), 2'(k));
      stageRw(2, 16'(16'h4000 + k), 2'(k + 1));
      applyStimulus(1'b0);
      if (k % 2 == 0) checkLane("burst", 2, 1'b1, 16'(16'h3000 + k / 2), 2'(k / 2));
      else            checkLane("burst", 2, 1'b1, 16'(16'h4000 + k / 2), 2'(k / 2 + 1));
      checkOutput("burst_afull", 2, 32'(port_almost_full[2]), (k >= 2) ? 32'd1 : 32'd0);
      checkOutput("burst_ovf",   2, 32'(overflow[2]),         (k >= 4) ? 32'd1 : 32'd0);
    end
    drain_d[0] = 16'h3003; drain_t[0] = 2'd3;
    drain_d[1] = 16'h4003; drain_t[1] = 2'd0;
    drain_d[2] = 16'h3004; drain_t[2] = 2'd0;
    drain_d[3] = 16'h3005; drain_t[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0);
      checkLane("drain", 2, 1'b1, drain_d[k], drain_t[k]);
    end
    applyStimulus(1'b0);
    checkLane("drain_done", 2, 1'b0, 16'h0000, 2'd0);
    checkOutput("drain_ovf_held", 2, 32'(overflow[2]), 32'd1);

    // Lane isolation: collisions on lane 0, r-only traffic on lane 1.
    for (int k = 0; k < 3; k++) begin
      stageR(0, 16'(16'h5000 + k), 2'(k));
      stageRw(0, 16'(16'h6000 + k), 2'(k));
      stageR(1, 16'(16'h7000 + k), 2'(k + 2));
      applyStimulus(1'b0);
      checkLane("iso_l1", 1, 1'b1, 16'(16'h7000 + k), 2'(k + 2));
    end
    checkLane("iso_l0", 0, 1'b1, 16'h5001, 2'd1);
    checkOutput("iso_afull", 0, 32'(port_almost_full[0]), 32'd1);

    // Reset with three entries buffered on lane 0; inputs during reset ignored.
    stageR(0, 16'hDEAD, 2'd3);
    applyStimulus(1'b1);
    checkOutput("rst_valid", 0, 32'(port_valid),       32'd0);
    checkOutput("rst_data",  0, 32'(port_data[31:0]),  32'd0);
    checkOutput("rst_afull", 0, 32'(port_almost_full), 32'd0);
    checkOutput("rst_ovf",   0, 32'(overflow),         32'd0);
    stageR(0, 16'hBEEF, 2'd2);
    applyStimulus(1'b0);
    checkLane("post_rst", 0, 1'b1, 16'hBEEF, 2'd2);
    applyStimulus(1'b0);
    checkLane("post_rst_idle", 0, 1'b0, 16'h0000, 2'd0);

    // Randomized traffic alternating light and heavy phases, rare resets.
    for (int c = 0; c < 800; c++) begin
      int pct;
      pct = ((c / 40) % 2 == 1) ? 90 : 30;
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 99) < pct) stageR(i, 16'($urandom), 2'($urandom));
        if ($urandom_range(0, 99) < pct) stageRw(i, 16'($urandom), 2'($urandom));
      end
      applyStimulus($urandom_range(0, 99) < 2);
    end
    for (int c = 0; c < DEPTH + 2; c++) applyStimulus(1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
